// File: rtl/uparc_ifu_pkg.sv
// Shared constants for the uPARC instruction fetch path: widths, FSM
// state encoding, the NOP word and the watchdog counter sizing helper.
package uparc_ifu_pkg;

  localparam int unsigned UPARC_ADDR_WIDTH  = 32;
  localparam int unsigned UPARC_INSTR_WIDTH = 32;

  // Legacy two-bit state encoding, kept stable for waveform/debug tooling.
  typedef logic [1:0] ifu_state_t;
  localparam ifu_state_t IFU_IDLE = 2'd0;
  localparam ifu_state_t IFU_REQ  = 2'd1;
  localparam ifu_state_t IFU_RESP = 2'd2;

  // All-zero word decodes as NOP; returned on bus error, timeout and reset.
  localparam logic [UPARC_INSTR_WIDTH-1:0] UPARC_NOP = '0;

  // Counter width able to hold 0..limit; one bit minimum when disabled.
  function automatic int unsigned wdog_width(input int unsigned limit);
    return (limit > 0) ? $clog2(limit + 1) : 1;
  endfunction

endpackage

// File: rtl/uparc_bus_wdog.sv
// Bus transaction watchdog: cleared when a transaction starts, counts while
// enabled, flags expiry on the LIMIT-th counted cycle. LIMIT=0 disables it.
module uparc_bus_wdog
  import uparc_ifu_pkg::*;
#(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned TW = wdog_width(LIMIT);
  localparam logic [TW-1:0] LAST = TW'((LIMIT > 0) ? LIMIT - 1 : 0);
  localparam logic [TW-1:0] SAT  = TW'(LIMIT);

  logic [TW-1:0] count;

  // Saturating cycle counter; holds at LIMIT instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && count != SAT) begin
      count <= count + 1'b1;
    end
  end

  assign expire = (LIMIT > 0) && enable && (count == LAST);

endmodule

// File: rtl/uparc_ifu.sv
// Instruction fetch unit: takes single-cycle read commands from fetch,
// rejects misaligned addresses, runs one bus read per command and returns
// the word (or NOP on error/timeout) together with a busy/stall signal.
module uparc_ifu
  import uparc_ifu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = UPARC_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = UPARC_INSTR_WIDTH,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_rd_cmd,
  output logic [DATA_WIDTH-1:0] o_instr_dat,
  output logic                  o_busy,
  output logic                  o_err_align,
  output logic                  o_err_bus,
  output logic [ADDR_WIDTH-1:0] o_bus_addr,
  output logic                  o_bus_rd,
  input  logic                  i_bus_ack,
  input  logic                  i_bus_rdy,
  input  logic                  i_bus_err,
  input  logic [DATA_WIDTH-1:0] i_bus_data
);

  ifu_state_t            state;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic                  idle;
  logic                  cmd_aligned;
  logic                  cmd_start;
  logic                  resp_fire;
  logic                  tmo_expire;
  logic                  done_ok;
  logic                  done_err;

  assign idle        = (state == IFU_IDLE);
  assign cmd_aligned = (i_addr[1:0] == 2'b00);
  assign cmd_start   = idle && i_rd_cmd && cmd_aligned;

  // Combinational so fetch stalls / sees the fault in the command cycle.
  assign o_err_align = idle && i_rd_cmd && !cmd_aligned;
  assign o_busy      = !idle || (i_rd_cmd && cmd_aligned);
  assign o_bus_addr  = addr_r;

  uparc_bus_wdog #(
    .LIMIT(TIMEOUT)
  ) u_wdog (
    .clk   (clk),
    .rst   (rst),
    .clear (cmd_start),
    .enable(!idle),
    .expire(tmo_expire)
  );

  // Bus response that ends the transaction; ack with rdy/err in REQ
  // short-circuits the RESP state.
  always_comb begin
    resp_fire = 1'b0;
    case (state)
      IFU_REQ:  resp_fire = i_bus_ack && (i_bus_rdy || i_bus_err);
      IFU_RESP: resp_fire = i_bus_rdy || i_bus_err;
      default:  resp_fire = 1'b0;
    endcase
  end

  // Error beats data; timeout only counts when the bus did not complete.
  assign done_err = (resp_fire && i_bus_err) || (!resp_fire && tmo_expire);
  assign done_ok  = resp_fire && !i_bus_err;

  // Transaction FSM with address latch, read strobe and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IFU_IDLE;
      addr_r      <= '0;
      o_bus_rd    <= 1'b0;
      o_instr_dat <= '0;
      o_err_bus   <= 1'b0;
    end else begin
      o_err_bus <= 1'b0;
      case (state)
        IFU_IDLE: begin
          if (cmd_start) begin
            addr_r   <= i_addr;
            o_bus_rd <= 1'b1;
            state    <= IFU_REQ;
          end
        end
        IFU_REQ: begin
          if (done_ok || done_err) begin
            o_bus_rd <= 1'b0;
            state    <= IFU_IDLE;
          end else if (i_bus_ack) begin
            o_bus_rd <= 1'b0;
            state    <= IFU_RESP;
          end
        end
        IFU_RESP: begin
          if (done_ok || done_err) begin
            state <= IFU_IDLE;
          end
        end
        default: begin
          o_bus_rd <= 1'b0;
          state    <= IFU_IDLE;
        end
      endcase
      if (done_ok) begin
        o_instr_dat <= i_bus_data;
      end
      if (done_err) begin
        o_instr_dat <= DATA_WIDTH'(UPARC_NOP);
        o_err_bus   <= 1'b1;
      end
    end
  end

`ifndef SYNTHESIS
  // Fetch must not issue a new command while a read is in flight.
  a_no_cmd_when_busy: assert property (@(posedge clk) disable iff (rst)
    (state != IFU_IDLE) |-> !i_rd_cmd)
    else $error("uparc_ifu: read command while transaction in flight");
`endif

endmodule

// File: tb/tb_uparc_ifu.sv
// Randomised scoreboard bench for uparc_ifu: a transaction-level model
// predicts each outcome, a negedge monitor checks whatever the DUT presents.
module tb_uparc_ifu;

  localparam int unsigned TMO   = 8;
  localparam int          NEVER = 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] i_addr = '0;
  logic        i_rd_cmd = 1'b0;
  logic [31:0] o_instr_dat;
  logic        o_busy;
  logic        o_err_align;
  logic        o_err_bus;
  logic [31:0] o_bus_addr;
  logic        o_bus_rd;
  logic        i_bus_ack = 1'b0;
  logic        i_bus_rdy = 1'b0;
  logic        i_bus_err = 1'b0;
  logic [31:0] i_bus_data = '0;

  uparc_ifu #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT   (TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_addr     (i_addr),
    .i_rd_cmd   (i_rd_cmd),
    .o_instr_dat(o_instr_dat),
    .o_busy     (o_busy),
    .o_err_align(o_err_align),
    .o_err_bus  (o_err_bus),
    .o_bus_addr (o_bus_addr),
    .o_bus_rd   (o_bus_rd),
    .i_bus_ack  (i_bus_ack),
    .i_bus_rdy  (i_bus_rdy),
    .i_bus_err  (i_bus_err),
    .i_bus_data (i_bus_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_align;
    logic [31:0] addr;
    logic [31:0] data;
    bit          err;
    int          rd;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;
  bit          prev_busy = 1'b0;
  bit          addr_bad = 1'b0;
  int          rd_cnt = 0;
  logic [31:0] held_dat = '0;
  logic [31:0] last_dat = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: checks completions, alignment faults and held outputs.
  always @(negedge clk) begin
    if (!mon_en) begin
      prev_busy = 1'b0;
      rd_cnt    = 0;
      addr_bad  = 1'b0;
    end else begin
      if (o_bus_rd) begin
        rd_cnt++;
        if (q.size() == 0 || o_bus_addr !== q[0].addr) addr_bad = 1'b1;
      end
      if (!o_busy && prev_busy) begin
        if (q.size() == 0 || q[0].is_align) begin
          checks++;
          errors++;
          $display("FAIL done_unexpected: completion at cycle %0d with no read expected", cyc);
        end else begin
          mon_e = q.pop_front();
          check("latency",  cyc,         mon_e.cyc);
          check("instr",    o_instr_dat, mon_e.data);
          check("err_bus",  o_err_bus,   mon_e.err);
          check("rd_cycles", rd_cnt,     mon_e.rd);
          check("addr_held", addr_bad,   1'b0);
          held_dat = mon_e.data;
        end
        rd_cnt   = 0;
        addr_bad = 1'b0;
      end else begin
        check("instr_hold",  o_instr_dat, held_dat);
        check("err_bus_off", o_err_bus,   1'b0);
      end
      if (o_err_align) begin
        if (q.size() == 0 || !q[0].is_align) begin
          checks++;
          errors++;
          $display("FAIL align_unexpected: align error at cycle %0d", cyc);
        end else begin
          mon_e = q.pop_front();
          check("align_cycle", cyc,      mon_e.cyc);
          check("align_busy",  o_busy,   1'b0);
          check("align_no_rd", o_bus_rd, 1'b0);
          check("align_instr", o_instr_dat, mon_e.data);
        end
      end
      prev_busy = o_busy;
    end
  end

  task automatic idle_junk();
    i_rd_cmd   = 1'b0;
    i_addr     = $urandom;
    i_bus_ack  = 1'($urandom % 2);
    i_bus_rdy  = 1'($urandom % 2);
    i_bus_err  = 1'($urandom % 2);
    i_bus_data = $urandom;
  endtask

  // One read: ack a cycles after the command, response r cycles after ack.
  task automatic do_txn(input logic [31:0] addr, input logic [31:0] data,
                        input int a, input int r, input bit err);
    exp_t e;
    int   done_t;
    int   end_t;
    bit   to;
    done_t = a + r;
    to     = (done_t > int'(TMO));
    end_t  = to ? int'(TMO) : done_t;
    @(posedge clk); #1;
    idle_junk();
    i_addr     = addr;
    i_rd_cmd   = 1'b1;
    e.is_align = 1'b0;
    e.addr     = addr;
    e.data     = (err || to) ? 32'h0 : data;
    e.err      = err || to;
    e.rd       = (a < end_t) ? a : end_t;
    e.cyc      = cyc + end_t + 1;
    q.push_back(e);
    last_dat   = e.data;
    for (int t = 1; t <= end_t; t++) begin
      @(posedge clk); #1;
      i_rd_cmd   = 1'b0;
      i_addr     = $urandom;
      i_bus_ack  = (t == a);
      i_bus_err  = (t == done_t) && err;
      i_bus_rdy  = (t == done_t) && (!err || ($urandom % 2 == 1));
      i_bus_data = (t == done_t) ? data : $urandom;
    end
    @(posedge clk); #1;
    idle_junk();
    repeat ($urandom % 3) begin
      @(posedge clk); #1;
      idle_junk();
    end
  endtask

  task automatic do_misaligned(input logic [31:0] addr);
    exp_t e;
    @(posedge clk); #1;
    idle_junk();
    i_addr     = addr;
    i_rd_cmd   = 1'b1;
    e.is_align = 1'b1;
    e.addr     = addr;
    e.data     = last_dat;
    e.err      = 1'b0;
    e.rd       = 0;
    e.cyc      = cyc;
    q.push_back(e);
    @(posedge clk); #1;
    idle_junk();
  endtask

  initial begin
    logic [31:0] ra;
    // Reset with stale bus activity
    repeat (3) begin
      @(posedge clk); #1;
      idle_junk();
    end
    @(negedge clk);
    check("rst_instr",    o_instr_dat, 32'h0);
    check("rst_bus_rd",   o_bus_rd,    1'b0);
    check("rst_bus_addr", o_bus_addr,  32'h0);
    check("rst_err_bus",  o_err_bus,   1'b0);
    @(posedge clk); #1;
    rst    = 1'b0;
    mon_en = 1'b1;
    idle_junk();

    // Directed cases
    do_txn(32'h100, 32'h2402_0005, 1, 0, 1'b0);   // zero-wait
    do_txn(32'h100, 32'h1111_2222, 3, 3, 1'b0);   // wait states, done T7
    do_misaligned(32'h102);
    do_txn(32'h104, 32'h3333_4444, 1, 1, 1'b1);   // bus error in RESP
    do_txn(32'h108, 32'h5555_6666, NEVER, 0, 1'b0); // never acked
    do_txn(32'h10C, 32'h7777_8888, 1, 0, 1'b0);   // serviced after timeout
    do_txn(32'h110, 32'h9999_AAAA, int'(TMO), 0, 1'b0); // completes on last cycle
    do_txn(32'h114, 32'hBBBB_CCCC, int'(TMO), 1, 1'b0); // one cycle too late

    // Randomised traffic
    for (int i = 0; i < 80; i++) begin
      ra = $urandom;
      if ($urandom % 6 == 0) begin
        ra[1:0] = 2'(1 + $urandom % 3);
        do_misaligned(ra);
      end else begin
        ra[1:0] = 2'b00;
        do_txn(ra, $urandom,
               ($urandom % 10 == 0) ? NEVER : int'(1 + $urandom % 7),
               int'($urandom % 4), ($urandom % 5 == 0));
      end
    end
    do_txn(32'h300, 32'hDEAD_BEEF, 1, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b0;
    check("queue_empty", q.size(), 0);

    // Reset during RESP, then a stale rdy afterwards
    i_bus_ack = 1'b0; i_bus_rdy = 1'b0; i_bus_err = 1'b0;
    @(posedge clk); #1;
    i_addr = 32'h200; i_rd_cmd = 1'b1;
    @(posedge clk); #1;
    i_rd_cmd = 1'b0; i_bus_ack = 1'b1;
    @(posedge clk); #1;
    i_bus_ack = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("rstmid_busy_resp", o_busy, 1'b1);
    check("rstmid_prev_data", o_instr_dat, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_busy",  o_busy,      1'b0);
    check("rstmid_bus_rd", o_bus_rd,   1'b0);
    check("rstmid_instr", o_instr_dat, 32'h0);
    @(posedge clk); #1;
    i_bus_rdy = 1'b1; i_bus_data = 32'h0000_1234;
    @(negedge clk);
    check("stale_busy", o_busy, 1'b0);
    @(posedge clk); #1;
    i_bus_rdy = 1'b0;
    @(negedge clk);
    check("stale_instr",   o_instr_dat, 32'h0);
    check("stale_err_bus", o_err_bus,   1'b0);
    check("stale_busy2",   o_busy,      1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop if something stalls the stimulus process.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "time limit");
  end

endmodule
